// File: rtl/ov2640_init_sequencer_pkg.sv
// ov2640_init_sequencer_pkg: shared FSM state type and OV2640 table constants.
package ov2640_init_sequencer_pkg;
  typedef enum logic [3:0] {IDLE, PWRUP, FETCH, LATCH, WRITE, SRST, NEXT, DONE, ERROR} state_t;
  localparam logic [15:0] SOFT_RESET_WORD = 16'h1280;
  localparam logic [7:0]  SCCB_BANK_REG   = 8'hFF;
endpackage

// File: rtl/ov2640_init_sequencer_if.sv
// ov2640_init_sequencer_if: single-write handshake between the sequencer and the SCCB write master.
interface ov2640_init_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_dev_id;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       wr_nack;
  modport master (output wr_req, wr_dev_id, wr_reg, wr_data, input wr_done, wr_nack);
  modport slave (input wr_req, wr_dev_id, wr_reg, wr_data, output wr_done, wr_nack);
endinterface

// File: rtl/ov2640_init_sequencer_delay_counter.sv
// init_delay_counter: cycle counter shared by the power-up and soft-reset waits; a length of 0 behaves as 1.
module init_delay_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        count_i,
  input  logic [23:0] len_i,
  output logic        expire_o
);
  logic [23:0] cnt_q, cnt_d;
  assign expire_o = count_i && (len_i == 24'd0 || cnt_q >= len_i - 24'd1);
  always_comb cnt_d = load_i ? '0 : (count_i && !expire_o) ? cnt_q + 24'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ov2640_init_sequencer.sv
// ov2640_init_sequencer: walks the external init ROM in order and issues each word as one SCCB write,
// retrying on NACK, pausing after the sensor soft reset, and reporting done/error.
module ov2640_init_sequencer
  import ov2640_init_sequencer_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          DATA_WIDTH   = 16,
  parameter int          TABLE_LEN    = 186,
  parameter logic [7:0]  DEV_ID       = 8'h60,
  parameter logic [23:0] PWRUP_CYCLES = 24'd1_000_000,
  parameter logic [23:0] SRST_CYCLES  = 24'd100_000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  auto_start_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  ov2640_init_sequencer_if.master sccb,
  output logic                  busy_o,
  output logic                  init_done_o,
  output logic                  init_error_o,
  output logic [ADDR_WIDTH-1:0] err_index_o
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, err_q, err_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [7:0]            reg_q, reg_d, data_q, data_d;
  logic                  gap_q, gap_d;
  logic [1:0]            boot_q, boot_d;
  logic                  go, dly_load, dly_expire, is_srst;
  // boot_q == 1 marks the first cycle after reset release, when auto_start fires
  assign boot_d  = (boot_q == 2'd2) ? boot_q : boot_q + 2'd1;
  assign go      = start_i || (auto_start_i && boot_q == 2'd1);
  assign is_srst = {reg_q, data_q} == SOFT_RESET_WORD;
  init_delay_counter u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (dly_load),
    .count_i (state_q == PWRUP || state_q == SRST),
    .len_i   (state_q == SRST ? SRST_CYCLES : PWRUP_CYCLES),
    .expire_o(dly_expire)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    retry_d  = retry_q;
    reg_d    = reg_q;
    data_d   = data_q;
    gap_d    = 1'b0;
    dly_load = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (go) begin
        state_d  = PWRUP;
        idx_d    = '0;
        err_d    = '0;
        retry_d  = '0;
        dly_load = 1'b1;
      end
      PWRUP: state_d = dly_expire ? FETCH : PWRUP;
      FETCH: state_d = LATCH;
      LATCH: begin
        reg_d   = rom_q_i[15:8];
        data_d  = rom_q_i[7:0];
        state_d = WRITE;
      end
      // gap_q is the one-cycle request drop between a NACK and its reissue
      WRITE: if (sccb.wr_done && !gap_q) begin
        if (!sccb.wr_nack) begin
          state_d  = is_srst ? SRST : NEXT;
          dly_load = is_srst;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          gap_d   = 1'b1;
        end else begin
          err_d   = idx_q;
          state_d = ERROR;
        end
      end
      SRST: state_d = dly_expire ? NEXT : SRST;
      NEXT: begin
        retry_d = '0;
        state_d = (idx_q == ADDR_WIDTH'(TABLE_LEN - 1)) ? DONE : FETCH;
        idx_d   = (idx_q == ADDR_WIDTH'(TABLE_LEN - 1)) ? idx_q : idx_q + ADDR_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      retry_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      gap_q   <= 1'b0;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      boot_q  <= boot_d;
    end
  assign rom_addr_o     = idx_q;
  assign sccb.wr_req    = state_q == WRITE && !gap_q;
  assign sccb.wr_dev_id = DEV_ID;
  assign sccb.wr_reg    = reg_q;
  assign sccb.wr_data   = data_q;
  assign busy_o         = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign init_done_o    = state_q == DONE;
  assign init_error_o   = state_q == ERROR;
  assign err_index_o    = err_q;
endmodule

// File: tb/tb_ov2640_init_sequencer.sv
// tb_ov2640_init_sequencer: a 3-entry DUT and a 186-entry DUT driven by an SCCB responder that acks after
// 5 request cycles with a per-entry NACK plan; a transaction-level model predicts writes, gaps and outcome.
module tb_ov2640_init_sequencer;
  localparam int MAXR = 3, SRST = 20, PWR = 10, BIG = 186;
  typedef struct {int inst; int run; int idx; logic [15:0] word; bit nack;} rec_t;
  typedef struct {int inst; int run; int gap;} gap_t;
  typedef struct {int n0; int n1; int n2; bit done; int eidx; int writes;} row_t;
  logic clk = 0, rst_n = 0;
  logic start[2], autos[2], req[2], done[2], nk[2], busy[2], idone[2], ierr[2], prev[2];
  logic [7:0] raddr[2], errx[2], wreg[2], wdata[2], devid[2];
  logic [15:0] rq[2], held[2];
  logic [15:0] rom[2][256];
  int nack[2][256];
  rec_t logq[$];
  gap_t gapq[$];
  int hold[2], lowc[2], att[2], cur_run[2], cur_idx[2], maxaddr[2], unstable[2];
  int run_id = 0, tests = 0, fails = 0;
  row_t rows[6];

  always #5 clk = ~clk;

  ov2640_init_sequencer_if bs();
  ov2640_init_sequencer_if bp();
  assign req[0] = bs.wr_req;  assign wreg[0] = bs.wr_reg;  assign wdata[0] = bs.wr_data;  assign devid[0] = bs.wr_dev_id;
  assign req[1] = bp.wr_req;  assign wreg[1] = bp.wr_reg;  assign wdata[1] = bp.wr_data;  assign devid[1] = bp.wr_dev_id;
  assign bs.wr_done = done[0]; assign bs.wr_nack = nk[0];
  assign bp.wr_done = done[1]; assign bp.wr_nack = nk[1];

  ov2640_init_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TABLE_LEN(3), .DEV_ID(8'h60),
    .PWRUP_CYCLES(24'd10), .SRST_CYCLES(24'd20), .MAX_RETRY(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .auto_start_i(autos[0]), .rom_addr_o(raddr[0]),
    .rom_q_i(rq[0]), .sccb(bs), .busy_o(busy[0]), .init_done_o(idone[0]), .init_error_o(ierr[0]),
    .err_index_o(errx[0]));
  ov2640_init_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TABLE_LEN(BIG), .DEV_ID(8'h60),
    .PWRUP_CYCLES(24'd10), .SRST_CYCLES(24'd20), .MAX_RETRY(3)) dut_p (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .auto_start_i(autos[1]), .rom_addr_o(raddr[1]),
    .rom_q_i(rq[1]), .sccb(bp), .busy_o(busy[1]), .init_done_o(idone[1]), .init_error_o(ierr[1]),
    .err_index_o(errx[1]));

  always @(posedge clk)
    for (int i = 0; i < 2; i++) rq[i] <= rom[i][raddr[i]];

  function automatic int attempt_no(int i);
    return (cur_run[i] == run_id && cur_idx[i] == int'(raddr[i])) ? att[i] : 0;
  endfunction

  // SCCB responder and bus monitor, evaluated on the falling edge
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        hold[i] <= 0; lowc[i] <= 0; done[i] <= 1'b0; nk[i] <= 1'b0; prev[i] <= 1'b0;
      end else begin
        done[i] <= 1'b0;
        nk[i]   <= 1'b0;
        prev[i] <= req[i];
        if (int'(raddr[i]) > maxaddr[i]) maxaddr[i] <= int'(raddr[i]);
        if (req[i]) begin
          if (!prev[i] && cur_run[i] == run_id) gapq.push_back('{i, run_id, lowc[i]});
          if (prev[i] && {wreg[i], wdata[i]} != held[i]) unstable[i] <= unstable[i] + 1;
          held[i] <= {wreg[i], wdata[i]};
          lowc[i] <= 0;
          if (hold[i] == 4) begin
            done[i] <= 1'b1;
            nk[i]   <= attempt_no(i) < nack[i][raddr[i]];
            logq.push_back('{i, run_id, int'(raddr[i]), {wreg[i], wdata[i]}, attempt_no(i) < nack[i][raddr[i]]});
            att[i]     <= attempt_no(i) + 1;
            cur_run[i] <= run_id;
            cur_idx[i] <= int'(raddr[i]);
            hold[i]    <= 0;
          end else hold[i] <= hold[i] + 1;
        end else begin
          hold[i] <= 0;
          lowc[i] <= lowc[i] + 1;
        end
      end
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs(int i);
    return {req[i], busy[i], idone[i], ierr[i], raddr[i], wreg[i], wdata[i], errx[i]};
  endfunction

  function automatic int nwrites(int i);
    int n = 0;
    foreach (logq[j]) if (logq[j].inst == i && logq[j].run == run_id) n++;
    return n;
  endfunction

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_end(input int i, input string name);
    int c = 0;
    while (!(idone[i] || ierr[i]) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check({name, " finished"}, c < 20000, 1);
  endtask

  // Reference: each entry in index order is attempted until acked or MAX_RETRY+1 NACKs; the request is low
  // 1 cycle after a NACK, 3 after an ack, and SRST more after the soft-reset word.
  task automatic check_run(input int i, input int len, input string name);
    rec_t exp[$], act[$];
    int eg[$], ag[$];
    int n, k, eidx, bad;
    bit ok;
    ok = 1'b1;
    eidx = 0;
    for (int e = 0; e < len; e++) begin
      n = nack[i][e];
      k = (n > MAXR) ? MAXR + 1 : n + 1;
      for (int a = 0; a < k; a++) exp.push_back('{i, run_id, e, rom[i][e], a < n});
      if (n > MAXR) begin
        ok = 1'b0;
        eidx = e;
        break;
      end
    end
    for (int j = 1; j < exp.size(); j++)
      eg.push_back(exp[j-1].nack ? 1 : (exp[j-1].word == 16'h1280) ? SRST + 3 : 3);
    foreach (logq[j]) if (logq[j].inst == i && logq[j].run == run_id) act.push_back(logq[j]);
    foreach (gapq[j]) if (gapq[j].inst == i && gapq[j].run == run_id) ag.push_back(gapq[j].gap);
    check({name, " write count"}, act.size(), exp.size());
    bad = 0;
    for (int j = 0; j < act.size() && j < exp.size(); j++)
      if (act[j].idx != exp[j].idx || act[j].word != exp[j].word || act[j].nack != exp[j].nack) bad++;
    check({name, " write order mismatches"}, bad, 0);
    check({name, " gap count"}, ag.size(), eg.size());
    bad = 0;
    for (int j = 0; j < ag.size() && j < eg.size(); j++) if (ag[j] != eg[j]) bad++;
    check({name, " gap length mismatches"}, bad, 0);
    check({name, " done/err/req/busy/err_index"}, {idone[i], ierr[i], req[i], busy[i], errx[i]},
          {ok, !ok, 1'b0, 1'b0, 8'(ok ? 0 : eidx)});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [15:0] w;
    start[0] = 1'b0; start[1] = 1'b0; autos[0] = 1'b1; autos[1] = 1'b0;
    for (int e = 0; e < 256; e++) begin
      rom[0][e] = 16'h0000; nack[0][e] = 0; nack[1][e] = 0;
      rom[1][e] = 16'hDEAD;
    end
    rom[0][0] = 16'hFF01; rom[0][1] = 16'h1280; rom[0][2] = 16'h1100;
    rom[1][0] = 16'hFF01; rom[1][1] = 16'h1280;
    for (int e = 2; e < BIG; e++) begin
      w = 16'($urandom());
      rom[1][e] = (w == 16'h1280) ? 16'h1281 : w;
    end
    rom[1][60] = rom[1][59];
    rom[1][100] = 16'hFF00;
    rows[0] = '{0, 0, 0, 1'b1, 0, 3};
    rows[1] = '{0, 1, 0, 1'b1, 0, 4};
    rows[2] = '{0, 0, 9, 1'b0, 2, 6};
    rows[3] = '{2, 3, 1, 1'b1, 0, 9};
    rows[4] = '{0, 4, 0, 1'b0, 1, 5};
    rows[5] = '{4, 0, 0, 1'b0, 0, 4};

    repeat (3) @(negedge clk);
    check("reset outputs small", outs(0), 36'h0);
    check("reset outputs big", outs(1), 36'h0);
    check("dev id", {devid[0], devid[1]}, 16'h6060);
    run_id = 1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("auto start edge1 busy", busy[0], 0);
    @(posedge clk); #1;
    check("auto start edge2 busy", busy[0], 1);
    check("big dut stays idle", busy[1], 0);
    c = 0;
    while (!req[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("pwrup to first request", c, PWR + 3);
    autos[0] = 1'b0;
    wait_end(0, "powerup");
    check_run(0, 3, "powerup");

    for (int r = 0; r < 6; r++) begin
      nack[0][0] = rows[r].n0; nack[0][1] = rows[r].n1; nack[0][2] = rows[r].n2;
      run_id++;
      pulse_start(0);
      check($sformatf("row%0d restart clears done", r), {idone[0], ierr[0], busy[0]}, 3'b001);
      wait_end(0, $sformatf("row%0d", r));
      check($sformatf("row%0d writes", r), nwrites(0), rows[r].writes);
      check($sformatf("row%0d outcome", r), {idone[0], ierr[0], errx[0]}, {rows[r].done, !rows[r].done, 8'(rows[r].eidx)});
      check_run(0, 3, $sformatf("row%0d", r));
    end
    nack[0][0] = 0; nack[0][1] = 0; nack[0][2] = 0;

    run_id++;
    pulse_start(0);
    c = 0;
    while (raddr[0] != 8'd1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("reached fetch of entry 1", c < 500, 1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_end(0, "start in fetch");
    check_run(0, 3, "start in fetch");

    autos[0] = 1'b1;
    run_id++;
    pulse_start(0);
    c = 0;
    while (!(req[0] && raddr[0] == 8'd1) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("reached write of entry 1", c < 500, 1);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", outs(0), 36'h0);
    run_id++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_end(0, "reset restart");
    check_run(0, 3, "reset restart");
    autos[0] = 1'b0;

    for (int e = 0; e < BIG; e++) nack[1][e] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
    run_id++;
    pulse_start(1);
    wait_end(1, "production");
    check_run(1, BIG, "production");
    check("production max rom_addr", maxaddr[1], BIG - 1);
    nack[1][$urandom_range(2, BIG - 1)] = 7;
    run_id++;
    pulse_start(1);
    wait_end(1, "production abort");
    check_run(1, BIG, "production abort");

    check("small max rom_addr", maxaddr[0], 2);
    check("wr_reg/wr_data stable during request", unstable[0] + unstable[1], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
